// File: rtl/idli_urx_drv_m_if.sv
// Push-side handshake between the Python-facing bench logic and the UART
// RX driver: a 16-bit word plus valid, with ready flowing back.
interface idli_urx_drv_m_if;
    logic [15:0] i_urd_data;
    logic        i_urd_vld;
    logic        o_urd_rdy;

    // The harness side drives words and valid, and watches ready.
    modport master (
        output i_urd_data,
        output i_urd_vld,
        input  o_urd_rdy
    );

    // The driver side consumes words and reports whether it has room.
    modport slave (
        input  i_urd_data,
        input  i_urd_vld,
        output o_urd_rdy
    );
endinterface

// File: rtl/idli_urx_drv_m.sv
// Bench-side UART driver for the core's serial receive pin. Words pushed by
// the harness are buffered in a small FIFO. Once the core reports that it
// can take a UART transaction, each word goes out as two 8N1 frames, low
// byte first, with every bit held for BIT_CYCLES clocks.
module idli_urx_drv_m #(
    parameter int DEPTH      = 4,
    parameter int BIT_CYCLES = 4
) (
    input  logic                       i_urd_gck,
    input  logic                       i_urd_rst,
    idli_urx_drv_m_if.slave            push_if,
    input  logic                       i_urd_core_rdy,
    output logic                       o_urd_tx,
    output logic                       o_urd_busy,
    output logic                       o_urd_sent,
    output logic [$clog2(DEPTH+1)-1:0] o_urd_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(BIT_CYCLES) + 1;
    localparam int LW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   sh_q, sh_d;
    logic          byte_q, byte_d;
    logic [2:0]    bit_q, bit_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic          tx_q, tx_d;

    logic [PW-1:0] wr_q, rd_q;
    logic [15:0]   mem_q [DEPTH];
    logic [PW-1:0] diff;

    logic          fifoEmpty;
    logic          fifoFull;
    logic          pushEn;
    logic          launch;
    logic          sentPulse;
    logic          cycLast;

    // The extra pointer MSB tells a full FIFO apart from an empty one.
    assign fifoEmpty = (wr_q == rd_q);
    assign fifoFull  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pushEn    = push_if.i_urd_vld && !fifoFull;
    assign cycLast   = (cyc_q == CW'(BIT_CYCLES - 1));
    assign diff      = wr_q - rd_q;

    assign push_if.o_urd_rdy = !fifoFull;
    assign o_urd_level       = LW'(diff);
    assign o_urd_tx          = tx_q;
    assign o_urd_busy        = (state_q != IDLE);
    assign o_urd_sent        = sentPulse;

    // FIFO storage; stale entries behind the read pointer need no reset.
    always_ff @(posedge i_urd_gck) begin
        if (pushEn) begin
            mem_q[wr_q[AW-1:0]] <= push_if.i_urd_data;
        end
    end

    // Frame sequencer: picks the next state and the line level it will drive.
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        byte_d    = byte_q;
        bit_d     = bit_q;
        cyc_d     = cyc_q;
        tx_d      = tx_q;
        launch    = 1'b0;
        sentPulse = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifoEmpty && i_urd_core_rdy) begin
                    launch  = 1'b1;
                    sh_d    = mem_q[rd_q[AW-1:0]];
                    byte_d  = 1'b0;
                    bit_d   = 3'd0;
                    cyc_d   = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (cycLast) begin
                    cyc_d   = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                    tx_d    = sh_q[0];
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            DATA: begin
                if (cycLast) begin
                    cyc_d = '0;
                    sh_d  = {1'b0, sh_q[15:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = sh_q[1];
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            STOP: begin
                if (cycLast) begin
                    cyc_d = '0;
                    if (!byte_q) begin
                        byte_d  = 1'b1;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        sentPulse = 1'b1;
                        state_d   = IDLE;
                        tx_d      = 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State, shifter and FIFO pointers; reset abandons any word in flight.
    always_ff @(posedge i_urd_gck) begin
        if (i_urd_rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            byte_q  <= 1'b0;
            bit_q   <= 3'd0;
            cyc_q   <= '0;
            tx_q    <= 1'b1;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            byte_q  <= byte_d;
            bit_q   <= bit_d;
            cyc_q   <= cyc_d;
            tx_q    <= tx_d;
            if (pushEn) begin
                wr_q <= wr_q + PW'(1);
            end
            if (launch) begin
                rd_q <= rd_q + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_idli_urx_drv_m.sv
// Directed bench for the UART RX driver with DEPTH=4 and BIT_CYCLES=4.
module tb_idli_urx_drv_m;

    logic       clk = 1'b0;
    logic       rst;
    logic       coreRdy;
    logic       tx;
    logic       busy;
    logic       sent;
    logic [2:0] level;

    int errors = 0;
    int checks = 0;

    idli_urx_drv_m_if pushIf ();

    idli_urx_drv_m #(
        .DEPTH      (4),
        .BIT_CYCLES (4)
    ) dut (
        .i_urd_gck      (clk),
        .i_urd_rst      (rst),
        .push_if        (pushIf),
        .i_urd_core_rdy (coreRdy),
        .o_urd_tx       (tx),
        .o_urd_busy     (busy),
        .o_urd_sent     (sent),
        .o_urd_level    (level)
    );

    // Free-running clock; the bench samples and drives on the falling edge.
    always #5 clk = ~clk;

    // Expected line level for each of the 80 clocks of one word: start bit,
    // eight data bits LSB first, stop bit, for the low byte then high byte.
    function automatic logic [79:0] expect_tx(input logic [15:0] w);
        logic [79:0] r;
        int b;
        int pos;
        int byteSel;
        r = '0;
        for (int k = 0; k < 80; k++) begin
            b       = k / 4;
            pos     = b % 10;
            byteSel = b / 10;
            if (pos == 0) begin
                r[7'(k)] = 1'b0;
            end else if (pos == 9) begin
                r[7'(k)] = 1'b1;
            end else begin
                r[7'(k)] = w[4'(byteSel * 8 + pos - 1)];
            end
        end
        return r;
    endfunction

    // Presents one word for exactly one rising edge, then drops valid.
    task automatic push_word(input logic [15:0] w);
        pushIf.i_urd_data = w;
        pushIf.i_urd_vld  = 1'b1;
        @(negedge clk);
        pushIf.i_urd_vld  = 1'b0;
    endtask

    // Waits (bounded) for a start bit, then records 80 clocks of line,
    // sent and busy. waitCycles counts falling edges up to the first low.
    task automatic capture_word(output logic [79:0] txs, output logic [79:0] sents,
                                output logic [79:0] busys, output int waitCycles,
                                output bit timedOut);
        waitCycles = 0;
        timedOut   = 1'b1;
        txs        = '0;
        sents      = '0;
        busys      = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            waitCycles++;
            if (tx === 1'b0) begin
                timedOut = 1'b0;
                break;
            end
        end
        for (int k = 0; k < 80; k++) begin
            if (k > 0) @(negedge clk);
            txs[7'(k)]   = tx;
            sents[7'(k)] = sent;
            busys[7'(k)] = busy;
        end
    endtask

    // Reset values, then ten quiet cycles with no activity on any output.
    task automatic test_reset();
        bit quiet;
        rst                = 1'b1;
        coreRdy            = 1'b0;
        pushIf.i_urd_vld   = 1'b0;
        pushIf.i_urd_data  = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({tx, pushIf.o_urd_rdy, busy, sent, level} !== 7'b1_1_0_0_000) begin
            errors++;
            $display("[TB] FAIL reset_values: got tx/rdy/busy/sent/level=%b want 1100000",
                     {tx, pushIf.o_urd_rdy, busy, sent, level});
        end
        quiet = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || sent !== 1'b0 || level !== 3'd0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("[TB] FAIL reset_idle: got activity during idle want tx=1 busy=0 sent=0 level=0");
        end
    endtask

    // Single word with the core ready: exact bit sequence and sent timing.
    task automatic test_single_frame();
        logic [79:0] txs, sents, busys, expTx, expSent, expBusy;
        int wc;
        bit to;
        expTx   = expect_tx(16'hA55A);
        expSent = 80'd1 << 79;
        expBusy = '1;
        coreRdy = 1'b1;
        push_word(16'hA55A);
        capture_word(txs, sents, busys, wc, to);
        checks++;
        if (to || wc != 1) begin
            errors++;
            $display("[TB] FAIL frame_launch: got wait=%0d timeout=%0d want wait=1", wc, to);
        end
        checks++;
        if (txs !== expTx) begin
            errors++;
            $display("[TB] FAIL frame_bits: got %h want %h", txs, expTx);
        end
        checks++;
        if (sents !== expSent) begin
            errors++;
            $display("[TB] FAIL frame_sent: got %h want %h", sents, expSent);
        end
        checks++;
        if (busys !== expBusy) begin
            errors++;
            $display("[TB] FAIL frame_busy: got %h want %h", busys, expBusy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1 || sent !== 1'b0) begin
            errors++;
            $display("[TB] FAIL frame_after: got busy=%b tx=%b sent=%b want 0 1 0", busy, tx, sent);
        end
    endtask

    // Word held back while the core is not ready, then released.
    task automatic test_core_wait();
        logic [79:0] txs, sents, busys, expTx;
        int wc;
        bit to;
        bit held;
        expTx   = expect_tx(16'h1234);
        coreRdy = 1'b0;
        push_word(16'h1234);
        held = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) held = 1'b0;
        end
        checks++;
        if (!held) begin
            errors++;
            $display("[TB] FAIL wait_hold: got line activity while core not ready want idle");
        end
        checks++;
        if (level !== 3'd1) begin
            errors++;
            $display("[TB] FAIL wait_level: got %0d want 1", level);
        end
        coreRdy = 1'b1;
        capture_word(txs, sents, busys, wc, to);
        checks++;
        if (to || wc != 1) begin
            errors++;
            $display("[TB] FAIL wait_release: got wait=%0d timeout=%0d want wait=1", wc, to);
        end
        checks++;
        if (txs !== expTx) begin
            errors++;
            $display("[TB] FAIL wait_bits: got %h want %h", txs, expTx);
        end
        checks++;
        if (level !== 3'd0) begin
            errors++;
            $display("[TB] FAIL wait_level_after: got %0d want 0", level);
        end
    endtask

    // Fill the FIFO, drop an overflow push, then drain back to back.
    task automatic test_back_to_back();
        logic [15:0] words [4];
        logic [79:0] txs, sents, busys, expTx, expSent;
        int wc;
        bit to;
        bit quiet;
        words[0] = 16'h0001;
        words[1] = 16'h8000;
        words[2] = 16'hC3A5;
        words[3] = 16'h7E18;
        expSent  = 80'd1 << 79;
        coreRdy  = 1'b0;
        for (int i = 0; i < 4; i++) push_word(words[i]);
        checks++;
        if (level !== 3'd4 || pushIf.o_urd_rdy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fill_full: got level=%0d rdy=%b want 4 0", level, pushIf.o_urd_rdy);
        end
        push_word(16'hDEAD);
        checks++;
        if (level !== 3'd4 || pushIf.o_urd_rdy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fill_overflow: got level=%0d rdy=%b want 4 0", level, pushIf.o_urd_rdy);
        end
        coreRdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expTx = expect_tx(words[i]);
            capture_word(txs, sents, busys, wc, to);
            checks++;
            if (to || wc != ((i == 0) ? 1 : 2)) begin
                errors++;
                $display("[TB] FAIL b2b_gap%0d: got wait=%0d timeout=%0d want %0d",
                         i, wc, to, (i == 0) ? 1 : 2);
            end
            checks++;
            if (txs !== expTx) begin
                errors++;
                $display("[TB] FAIL b2b_bits%0d: got %h want %h", i, txs, expTx);
            end
            checks++;
            if (sents !== expSent) begin
                errors++;
                $display("[TB] FAIL b2b_sent%0d: got %h want %h", i, sents, expSent);
            end
        end
        quiet = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || sent !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet || level !== 3'd0 || pushIf.o_urd_rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_drained: got quiet=%0d level=%0d rdy=%b want 1 0 1",
                     quiet, level, pushIf.o_urd_rdy);
        end
    endtask

    // Core ready drops during the low-byte stop bit; the high byte follows.
    task automatic test_core_drop();
        logic [79:0] txs, sents, busys, expTx;
        int wc;
        bit to;
        expTx   = expect_tx(16'h3C96);
        coreRdy = 1'b1;
        push_word(16'h3C96);
        fork
            capture_word(txs, sents, busys, wc, to);
            begin
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (tx === 1'b0) break;
                end
                repeat (38) @(negedge clk);
                coreRdy = 1'b0;
            end
        join
        checks++;
        if (to || txs !== expTx) begin
            errors++;
            $display("[TB] FAIL drop_bits: got %h timeout=%0d want %h", txs, to, expTx);
        end
        checks++;
        if (sents !== (80'd1 << 79)) begin
            errors++;
            $display("[TB] FAIL drop_sent: got %h want only last cycle", sents);
        end
        @(negedge clk);
        coreRdy = 1'b1;
    endtask

    // Reset in the middle of the data bits, then a clean all-ones word.
    task automatic test_reset_mid_frame();
        logic [79:0] txs, sents, busys, expTx;
        int wc;
        bit to;
        bit quiet;
        expTx   = expect_tx(16'hFFFF);
        coreRdy = 1'b1;
        push_word(16'h0F0F);
        push_word(16'h5555);
        checks++;
        if (level !== 3'd1) begin
            errors++;
            $display("[TB] FAIL rstmid_pushpop_level: got %0d want 1", level);
        end
        for (int i = 0; i < 200; i++) begin
            if (tx === 1'b0) break;
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx, busy, sent, level} !== 6'b1_0_0_000) begin
            errors++;
            $display("[TB] FAIL rstmid_abort: got tx/busy/sent/level=%b want 100000",
                     {tx, busy, sent, level});
        end
        rst   = 1'b0;
        quiet = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || sent !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("[TB] FAIL rstmid_quiet: got line activity or sent after reset want idle");
        end
        push_word(16'hFFFF);
        capture_word(txs, sents, busys, wc, to);
        checks++;
        if (to || wc != 1 || txs !== expTx) begin
            errors++;
            $display("[TB] FAIL rstmid_ffff: got %h wait=%0d want %h wait=1", txs, wc, expTx);
        end
        checks++;
        if (sents !== (80'd1 << 79)) begin
            errors++;
            $display("[TB] FAIL rstmid_sent: got %h want only last cycle", sents);
        end
    endtask

    // Scenario sequence, finishing with the one-line summary.
    initial begin
        rst               = 1'b1;
        coreRdy           = 1'b0;
        pushIf.i_urd_vld  = 1'b0;
        pushIf.i_urd_data = 16'h0000;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_core_wait();
        test_back_to_back();
        test_core_drop();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/idli_urx_drv_m.md
# idli_urx_drv_m

Bench-side UART driver that feeds 16-bit words into the core's serial receive pin. It buffers words pushed by the Python test harness in a small FIFO and waits for the bench's UART-ready indication (core stalled on UART input, receiver not about to fill). It then serialises each word as two 8N1 frames, low byte first, onto the line connected to the core's UART RX input. It sits directly upstream of the core's UART receiver inside the debug bench.

## Interface
- DEPTH, 4: FIFO capacity in 16-bit words; power of two, ≥2.
- BIT_CYCLES, 4: GCK cycles each UART bit is held; ≥1.

- i_urd_gck  in  1  bench/core clock (gck).
- i_urd_rst  in  1  reset. One clock; reset is synchronous and active-high.
- i_urd_data  in  16  word to enqueue.
- i_urd_vld  in  1  push request; accepted when i_urd_vld && o_urd_rdy.
- o_urd_rdy  out  1  FIFO not full.
- i_urd_core_rdy  in  1  core can accept a new 16-bit UART transaction.
- o_urd_tx  out  1  serial line to core UART RX; idle high.
- o_urd_busy  out  1  frame pair in progress (state != IDLE).
- o_urd_sent  out  1  one-cycle pulse: word fully transmitted.
- o_urd_level  out  $clog2(DEPTH+1)  words currently in FIFO.

## Operation
- FIFO: wr/rd pointers of $clog2(DEPTH)+1 bits; full when MSBs differ and the rest are equal; empty when equal. Pointers wrap naturally. o_urd_level = wr - rd, modulo pointer width.
- Push is ignored when full, even if a pop occurs the same cycle. o_urd_rdy depends only on registered state.
- FSM states: IDLE, START, DATA, STOP. Registers:
  - 16-bit shift register sh_q.
  - byte select byte_q (0 = low, 1 = high).
  - 3-bit bit index bit_q.
  - bit-cycle counter cyc_q, width $clog2(BIT_CYCLES)+1.
- IDLE: o_urd_tx=1.
  - Launch in cycle L when FIFO non-empty and i_urd_core_rdy=1.
  - On launch: pop head into sh_q, byte_q=0, cyc_q=0, go to START.
  - If FIFO is empty or core_rdy=0: remain in IDLE.
- START: tx=0 for BIT_CYCLES cycles, then go to DATA with bit_q=0.
- DATA: tx=sh_q[0]. Each bit is held BIT_CYCLES cycles, then sh_q shifts right by 1 (zero fill) and bit_q increments. After bit_q=7 completes, go to STOP.
- STOP: tx=1 for BIT_CYCLES cycles.
  - If byte_q=0: set byte_q=1 and go to START. i_urd_core_rdy is not re-checked between bytes.
  - If byte_q=1: assert o_urd_sent for the final STOP cycle, then go to IDLE.
- i_urd_core_rdy is sampled only in IDLE. Deassertion mid-word has no effect.
- o_urd_tx is registered and reflects the current state's bit value.

## Timing
- Reset values:
  - o_urd_tx=1, o_urd_rdy=1, o_urd_busy=0, o_urd_sent=0, o_urd_level=0.
  - FIFO emptied, FSM in IDLE.
- Reset asserted mid-frame aborts the word with no o_urd_sent. o_urd_tx is high the cycle after reset is sampled.
- A word pushed in cycle N is countable (level) in cycle N+1. The earliest launch is cycle N+1.
- Launch in cycle L: tx low from L+1. Word occupies cycles L+1 .. L+20·BIT_CYCLES.
- o_urd_sent is high in cycle L+20·BIT_CYCLES; state is IDLE in the next cycle.
- Back-to-back: the next launch may occur in the first IDLE cycle. Minimum inter-word gap is 1 idle cycle (tx high).
- o_urd_busy is high from L+1 through the o_urd_sent cycle.
- Push and pop in the same cycle (not full): level unchanged.
- Pop happens only at launch, so the level drops in cycle L+1.

## Test plan
- Reset, then idle 10 cycles -> tx=1, rdy=1, busy=0, level=0, sent never asserted.
- BIT_CYCLES=4; push 0xA55A with core_rdy=1 -> tx sequence per bit:
  - 0, then 0x5A LSB first (0,1,0,1,1,0,1,0), then 1;
  - 0, then 0xA5 LSB first (1,0,1,0,0,1,0,1), then 1;
  - each bit 4 cycles; sent pulses exactly once, 80 cycles after the first low.
- Push 0x1234 with core_rdy=0 for 50 cycles -> tx stays 1 and level=1. Raise core_rdy -> start bit appears the next cycle.
- Fill DEPTH=4 words with core_rdy=0 -> rdy=0 and level=4. A fifth push is dropped. Release core_rdy -> exactly 4 sent pulses in push order.
- Drop core_rdy between the low-byte stop and the high-byte start -> the high byte is still sent without a gap.
- Assert reset in the middle of the DATA phase -> tx=1 next cycle, level=0, no sent pulse. A subsequent push of 0xFFFF transmits correctly.
